// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
//
// Purpose: FSM state encoding, double-dabble adjust constants and the
//          iteration counter width helper used by bcd16_convert and
//          bcd_digit_adj.
// Ports:   none (package).

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Counter must hold 0..width-1; keep at least one bit for width==1.
  function automatic int bcd_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble per-digit add-3 correction
//
// Purpose: combinational adjust of one BCD scratch digit before the shift:
//          digits 5..9 get +3 so the following left shift carries correctly.
// Ports:
//   digit    in  4  scratch digit before adjustment
//   adjusted out 4  digit after conditional +3 (max 9+3=12, fits 4 bits)

module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= BCD_ADJ_THRESH) begin
      adjusted = digit + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bcd16_convert.sv
// rtl/bcd16_convert.sv - sequential double-dabble binary to packed BCD converter
//
// Purpose: converts a WIDTH-bit binary value (divider quotient) into DIGITS
//          packed BCD digits, one shift/adjust iteration per clock.
//          Optional macro BCD_SIGNED_EN: treat in_value as two's complement,
//          convert its magnitude and report the sign on out_neg.
// Ports:
//   clock     in  1         system clock
//   reset     in  1         synchronous active-high reset
//   in_value  in  WIDTH     binary value, captured only at start
//   in_start  in  1         start request, honoured only while idle
//   out_bcd   out 4*DIGITS  packed BCD, digit 0 in bits [3:0]
//   out_neg   out 1         sign of the last converted value
//   out_valid out 1         one-cycle pulse when out_bcd/out_neg update
//   out_done  out 1         high while idle and ready for in_start

module bcd16_convert
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  in_start,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_valid,
  output logic                  out_done
);

  localparam int CNT_W = bcd_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0]            value_sr;
  logic [4*DIGITS-1:0]         scratch;
  logic [4*DIGITS-1:0]         scratch_adj;
  logic [4*DIGITS+WIDTH-1:0]   shifted;
  logic [CNT_W-1:0]            iter_cnt;
  logic [WIDTH-1:0]            load_value;

  logic start_load;
  logic shift_en;
  logic finish;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_start) state_next = SHIFT;
      SHIFT:   if (iter_cnt == LAST_ITER) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    out_done   = 1'b0;
    start_load = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        out_done   = 1'b1;
        start_load = in_start;
      end
      SHIFT:   shift_en = 1'b1;
      DONE:    finish   = 1'b1;
      default: ;
    endcase
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (scratch[4*g +: 4]),
      .adjusted (scratch_adj[4*g +: 4])
    );
  end

  // Adjust first, then shift the whole {scratch, value} pair left by one;
  // the value MSB enters digit 0 and the top scratch bit falls off.
  assign shifted = {scratch_adj, value_sr} << 1;

`ifdef BCD_SIGNED_EN
  logic neg_pending;

  always_comb begin
    load_value = in_value;
    if (in_value[WIDTH-1]) begin
      load_value = ~in_value + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      neg_pending <= 1'b0;
      out_neg     <= 1'b0;
    end else begin
      if (start_load) neg_pending <= in_value[WIDTH-1];
      if (finish)     out_neg     <= neg_pending;
    end
  end
`else
  assign load_value = in_value;
  assign out_neg    = 1'b0;
`endif

  // Datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      value_sr  <= '0;
      scratch   <= '0;
      iter_cnt  <= '0;
      out_bcd   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= finish;
      if (start_load) begin
        value_sr <= load_value;
        scratch  <= '0;
        iter_cnt <= '0;
      end else if (shift_en) begin
        value_sr <= shifted[WIDTH-1:0];
        scratch  <= shifted[4*DIGITS+WIDTH-1:WIDTH];
        iter_cnt <= iter_cnt + CNT_W'(1);
      end
      if (finish) begin
        out_bcd <= scratch;
      end
    end
  end

endmodule

// File: tb/tb_bcd16_convert.sv
// tb/tb_bcd16_convert.sv - scoreboard bench for bcd16_convert

module tb_bcd16_convert;

  logic        clock;
  logic        reset;
  logic [15:0] in_value;
  logic        in_start;
  logic [19:0] out_bcd;
  logic        out_neg;
  logic        out_valid;
  logic        out_done;

  int cmp_count = 0;
  int err_count = 0;

  logic [20:0] exp_q[$];
  logic [20:0] last_res;

  bcd16_convert #(.WIDTH(16), .DIGITS(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_value  (in_value),
    .in_start  (in_start),
    .out_bcd   (out_bcd),
    .out_neg   (out_neg),
    .out_valid (out_valid),
    .out_done  (out_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [20:0] model(input logic [15:0] v);
    int m;
    bit n;
    logic [19:0] r;
`ifdef BCD_SIGNED_EN
    n = v[15];
    m = n ? (65536 - int'(v)) : int'(v);
`else
    n = 1'b0;
    m = int'(v);
`endif
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {n, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_compare(input string tag);
    logic [20:0] e;
    check({tag, "_q_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_bcd"}, 32'(out_bcd), 32'(e[19:0]));
      check({tag, "_neg"}, 32'(out_neg), 32'(e[20]));
      last_res = e;
    end
  endtask

  // Present a start for one cycle; returns at the negedge after it was sampled.
  task automatic issue(input logic [15:0] v);
    in_value = v;
    in_start = 1'b1;
    exp_q.push_back(model(v));
    @(negedge clock);
    in_start = 1'b0;
  endtask

  // Returns at the negedge where out_valid is observed (or after the bound).
  task automatic wait_valid(input string tag, input bit interfere);
    int k;
    bit done_ok;
    bit hold_ok;
    k = 0;
    done_ok = 1'b1;
    hold_ok = 1'b1;
    check({tag, "_pulse_width"}, 32'(out_valid), 32'd0);
    while (out_valid !== 1'b1 && k < 40) begin
      if (out_done !== 1'b0) done_ok = 1'b0;
      if ({out_neg, out_bcd} !== last_res) hold_ok = 1'b0;
      @(negedge clock);
      k++;
      if (interfere && k >= 3 && k <= 10) begin
        in_start = 1'b1;
        in_value = 16'd4321;
      end else begin
        in_start = 1'b0;
      end
    end
    check({tag, "_latency"}, 32'(k), 32'd17);
    check({tag, "_done_low"}, 32'(done_ok), 32'd1);
    check({tag, "_hold_prev"}, 32'(hold_ok), 32'd1);
    if (out_valid === 1'b1) begin
      check({tag, "_done_at_valid"}, 32'(out_done), 32'd1);
      pop_compare(tag);
    end
  endtask

  task automatic convert(input string tag, input logic [15:0] v);
    issue(v);
    wait_valid(tag, 1'b0);
    @(negedge clock);
  endtask

  initial begin
    int prev_pos;
    int nvalid;
    bit prev_valid;
    bit saw_valid;

    reset    = 1'b1;
    in_start = 1'b0;
    in_value = '0;
    last_res = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    check("rst_bcd",   32'(out_bcd),   32'd0);
    check("rst_neg",   32'(out_neg),   32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done",  32'(out_done),  32'd1);
    @(negedge clock);

    convert("v488", 16'd488);
    check("v488_const", 32'(last_res[19:0]), 32'h00488);
    convert("v0", 16'd0);
    convert("v9999", 16'd9999);
    check("v9999_const", 32'(last_res[19:0]), 32'h09999);
`ifndef BCD_SIGNED_EN
    convert("v65535", 16'd65535);
    check("v65535_const", 32'(last_res[19:0]), 32'h65535);
`endif

    // Busy restarts ignored; the next start right at the valid cycle is taken.
    issue(16'd1234);
    wait_valid("v1234_busy", 1'b1);
    check("v1234_const", 32'(last_res[19:0]), 32'h01234);
    issue(16'd4321);
    wait_valid("v4321_b2b", 1'b0);
    check("v4321_const", 32'(last_res[19:0]), 32'h04321);
    @(negedge clock);

    // Reset mid-conversion: edge 8 after the start edge.
    in_value = 16'd500;
    in_start = 1'b1;
    @(negedge clock);
    in_start = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_bcd",   32'(out_bcd),   32'd0);
    check("abort_done",  32'(out_done),  32'd1);
    check("abort_valid", 32'(out_valid), 32'd0);
    saw_valid = 1'b0;
    repeat (25) begin
      @(negedge clock);
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    check("abort_no_valid", 32'(saw_valid), 32'd0);
    last_res = '0;
    convert("v77", 16'd77);
    check("v77_const", 32'(last_res[19:0]), 32'h00077);

`ifdef BCD_SIGNED_EN
    convert("neg1", 16'hFFFF);
    check("neg1_const", 32'(last_res), 32'h100001);
    convert("negmin", 16'h8000);
    check("negmin_const", 32'(last_res), 32'h132768);
    convert("posmax", 16'h7FFF);
    check("posmax_const", 32'(last_res), 32'h032767);
`endif

    // Continuous start: period WIDTH+2, single-cycle pulses.
    in_value = 16'd321;
    in_start = 1'b1;
    repeat (3) exp_q.push_back(model(16'd321));
    prev_pos   = -1;
    nvalid     = 0;
    prev_valid = 1'b0;
    for (int cyc = 0; cyc < 80 && nvalid < 3; cyc++) begin
      @(negedge clock);
      if (out_valid === 1'b1) begin
        check("hold_pulse_width", 32'(prev_valid), 32'd0);
        pop_compare("hold");
        if (prev_pos >= 0) check("hold_period", 32'(cyc - prev_pos), 32'd18);
        prev_pos = cyc;
        nvalid++;
        if (nvalid == 3) in_start = 1'b0;
      end
      prev_valid = out_valid;
    end
    in_start = 1'b0;
    check("hold_count", 32'(nvalid), 32'd3);
    @(negedge clock);
    check("hold_after_pulse", 32'(out_valid), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
